// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch front end
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, HALT} fetch_state_t;
  localparam logic [3:0] HLT_OPCODE_DEF = 4'hF;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  typedef struct packed {
    logic [DATA_W_DEF-1:0] inst;
    logic [ADDR_W_DEF-1:0] pc_next;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory, redirect and decode handshake bundle
interface fetch_queue_if #(parameter int DATA_W = 16, parameter int ADDR_W = 16);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [DATA_W-1:0] imem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc_next;
  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc_next,
    input  imem_valid, imem_data, redirect, redirect_pc, id_ready
  );
  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc_next,
    output imem_valid, imem_data, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular-buffer queue with priority flush and occupancy count
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [WIDTH-1:0]               data_i,
  output logic [WIDTH-1:0]               data_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk)
    if (rst || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + PW'(push_i);
      rd_q  <= rd_q + PW'(pop_i);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: variable-latency instruction fetch feeding decode through a queue
module fetch_queue import fetch_pkg::*; #(
  parameter int               DATA_W     = 16,
  parameter int               ADDR_W     = 16,
  parameter int               DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [3:0]       HLT_OPCODE = HLT_OPCODE_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  fetch_queue_if.master              bus,
  output logic [ADDR_W-1:0]          pc,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] pc_next;
  } entry_t;
  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              disc_q, disc_d;
  logic              fire, hlt, push, pop, req_idle, req_b2b;
  entry_t            head, wdata;
  assign pc_inc   = pc_q + ADDR_W'(2);
  assign fire     = bus.imem_valid && state_q == WAIT && !disc_q;
  assign hlt      = bus.imem_data[DATA_W-1 -: 4] == HLT_OPCODE;
  assign push     = fire && !bus.redirect;
  assign pop      = bus.id_valid && bus.id_ready;
  assign wdata    = '{inst: bus.imem_data, pc_next: pc_inc};
  // a request always reserves a slot, counting the response still in flight
  assign req_idle = state_q == IDLE && count < CW'(DEPTH);
  assign req_b2b  = push && !hlt && count < CW'(DEPTH-1);
  assign bus.imem_req  = !rst && !bus.redirect && (req_idle || req_b2b);
  assign bus.imem_addr = !bus.imem_req ? '0 : req_b2b ? pc_inc : pc_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    disc_d  = disc_q;
    if (bus.redirect) begin
      pc_d    = bus.redirect_pc & ~ADDR_W'(1);
      disc_d  = state_q == WAIT && !bus.imem_valid;
      state_d = disc_d ? WAIT : IDLE;
    end else if (state_q == IDLE && bus.imem_req) begin
      state_d = WAIT;
    end else if (state_q == WAIT && bus.imem_valid) begin
      disc_d  = 1'b0;
      state_d = disc_q ? IDLE : hlt ? HALT : bus.imem_req ? WAIT : IDLE;
      pc_d    = fire && !hlt ? pc_inc : pc_q;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      disc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      disc_q  <= disc_d;
    end
  fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.redirect),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wdata),
    .data_o  (head),
    .count_o (count)
  );
  assign bus.id_valid   = count != '0;
  assign bus.id_inst    = bus.id_valid ? head.inst : '0;
  assign bus.id_pc_next = bus.id_valid ? head.pc_next : '0;
  assign pc     = pc_q;
  assign halted = state_q == HALT;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a queue-level model
module tb_fetch_queue;
  import fetch_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {int due; logic [15:0] addr;} rsp_t;
  logic clk = 0, rst = 1;
  logic [15:0] pc;
  logic halted;
  logic [2:0] count;
  always #5 clk = ~clk;
  fetch_queue_if #(.DATA_W(16), .ADDR_W(16)) bus();
  fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus), .pc(pc), .halted(halted), .count(count));
  int n_cmp = 0, n_bad = 0, cyc = 0, lat_min = 1, lat_max = 1;
  bit rand_data = 0, hlt_on = 0, m_known = 0, m_out = 0, m_disc = 0, m_halt = 0;
  logic [15:0] m_pc = 0;
  fq_entry_t mq[$], pop_log[$];
  rsp_t pend[$];
  logic [15:0] req_log[$];
  int req_cyc[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (rand_data) return 16'($urandom);
    if (hlt_on && a == 16'h0006) return 16'hF000;
    return 16'h1000 + (a >> 1);
  endfunction
  // one clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input bit r, input logic [15:0] rpc, input bit rdy);
    bit v, er;
    logic [15:0] d, ea;
    fq_entry_t h;
    int k, due;
    bus.redirect = r; bus.redirect_pc = rpc; bus.id_ready = rdy;
    v = pend.size() > 0 && pend[0].due <= cyc;
    d = v ? mem_word(pend[0].addr) : 16'($urandom);
    if (v) void'(pend.pop_front());
    bus.imem_valid = v; bus.imem_data = d;
    #1;
    er = !rst && !r && !m_halt &&
         ((!m_out && mq.size() < DEPTH) ||
          (m_out && v && !m_disc && d[15:12] != 4'hF && mq.size() + 1 < DEPTH));
    ea = er ? (m_out ? m_pc + 16'd2 : m_pc) : 16'd0;
    h = (mq.size() != 0) ? mq[0] : fq_entry_t'(0);
    if (m_known) begin
      chk("imem_req", bus.imem_req, er);
      chk("imem_addr", bus.imem_addr, ea);
      chk("id_valid", bus.id_valid, mq.size() != 0);
      chk("id_inst", bus.id_inst, h.inst);
      chk("id_pc_next", bus.id_pc_next, h.pc_next);
      chk("pc", pc, m_pc);
      chk("halted", halted, m_halt);
      chk("count", count, mq.size());
    end
    if (bus.imem_req) begin
      req_log.push_back(bus.imem_addr); req_cyc.push_back(cyc);
      due = cyc + int'($urandom_range(lat_max, lat_min));
      k = 0;
      while (k < pend.size() && pend[k].due <= due) k++;
      pend.insert(k, '{due, bus.imem_addr});
    end
    if (!rst && !r && bus.id_valid && rdy) pop_log.push_back(fq_entry_t'{bus.id_inst, bus.id_pc_next});
    if (rst) begin
      mq.delete(); m_pc = 16'h0000; m_out = 0; m_disc = 0; m_halt = 0; m_known = 1;
    end else if (r) begin
      mq.delete(); m_pc = {rpc[15:1], 1'b0}; m_halt = 0;
      if (m_out && !v) m_disc = 1;
      else begin m_out = 0; m_disc = 0; end
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (m_out && v) begin
        if (m_disc) begin m_disc = 0; m_out = 0; end
        else begin
          mq.push_back(fq_entry_t'{d, m_pc + 16'd2});
          if (d[15:12] == 4'hF) m_halt = 1;
          else m_pc = m_pc + 16'd2;
          m_out = er;
        end
      end else if (!m_out) m_out = er;
    end
    @(negedge clk);
    cyc++;
  endtask
  task automatic do_reset(input bit clr);
    rst = 1;
    step(0, 0, 1);
    step(0, 0, 1);
    rst = 0;
    if (clr) pend.delete();
    req_log.delete(); req_cyc.delete(); pop_log.delete();
  endtask
  initial begin
    int n, rc, c0;
    bus.redirect = 0; bus.redirect_pc = 0; bus.id_ready = 0; bus.imem_valid = 0; bus.imem_data = 0;
    @(negedge clk);
    // free run, latency 1
    do_reset(1);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_count", count, 0);
    chk("rst_halted", halted, 0);
    c0 = cyc;
    repeat (10) step(0, 0, 1);
    chk("fr_first", req_cyc[0], c0);
    chk("fr_req0", req_log[0], 16'h0000);
    chk("fr_req1", req_log[1], 16'h0002);
    chk("fr_req3", req_log[3], 16'h0006);
    chk("fr_b2b", req_cyc[3] - req_cyc[0], 3);
    chk("fr_inst0", pop_log[0].inst, 16'h1000);
    chk("fr_pcn0", pop_log[0].pc_next, 16'h0002);
    chk("fr_inst1", pop_log[1].inst, 16'h1001);
    chk("fr_pcn1", pop_log[1].pc_next, 16'h0004);
    chk("fr_rate", pop_log.size(), 8);
    // backpressure
    do_reset(1);
    repeat (8) step(0, 0, 0);
    chk("bp_full", count, 4);
    chk("bp_nreq", req_log.size(), 4);
    repeat (3) step(0, 0, 0);
    chk("bp_stall", req_log.size(), 4);
    step(0, 0, 1);
    chk("bp_pop", count, 3);
    chk("bp_pop_inst", pop_log[0].inst, 16'h1000);
    repeat (3) step(0, 0, 0);
    chk("bp_refill", count, 4);
    chk("bp_one_req", req_log.size(), 5);
    chk("bp_addr", req_log[4], 16'h0008);
    // redirect during WAIT, latency 3
    lat_min = 3; lat_max = 3;
    do_reset(1);
    step(1, 16'h0004, 1);
    step(0, 0, 1);
    step(1, 16'h0041, 1);
    repeat (2) step(0, 0, 1);
    chk("rd_dropped", count, 0);
    chk("rd_req0", req_log[0], 16'h0004);
    chk("rd_nreq", req_log.size(), 1);
    step(0, 0, 1);
    chk("rd_req1", req_log[1], 16'h0040);
    repeat (5) step(0, 0, 1);
    chk("rd_inst", pop_log[0].inst, 16'h1020);
    // HLT
    lat_min = 1; lat_max = 1; hlt_on = 1;
    do_reset(1);
    repeat (10) step(0, 0, 0);
    chk("hlt_halted", halted, 1);
    chk("hlt_pc", pc, 16'h0006);
    chk("hlt_count", count, 4);
    chk("hlt_nreq", req_log.size(), 4);
    step(1, 16'h0100, 0);
    chk("hlt_clear", halted, 0);
    chk("hlt_flush", count, 0);
    step(0, 0, 0);
    chk("hlt_redir", req_log[4], 16'h0100);
    hlt_on = 0;
    // address wrap
    do_reset(1);
    step(1, 16'hFFFF, 1);
    repeat (4) step(0, 0, 1);
    chk("wr_req0", req_log[0], 16'hFFFE);
    chk("wr_req1", req_log[1], 16'h0000);
    chk("wr_pcn0", pop_log[0].pc_next, 16'h0000);
    // redirect + response + pop in one cycle with two entries queued
    lat_min = 3; lat_max = 3;
    do_reset(1);
    for (int i = 0; i < 40 && !(mq.size() == 2 && pend.size() != 0 && pend[0].due <= cyc); i++) step(0, 0, 0);
    chk("sim_setup", count, 2);
    rc = cyc; n = req_log.size();
    step(1, 16'h0080, 1);
    chk("sim_count", count, 0);
    chk("sim_noreq", req_log.size(), n);
    step(0, 0, 1);
    chk("sim_addr", req_log[n], 16'h0080);
    chk("sim_when", req_cyc[n], rc + 1);
    repeat (5) step(0, 0, 1);
    chk("sim_inst", pop_log[0].inst, 16'h1040);
    // randomized run
    rand_data = 1; lat_min = 1; lat_max = 3;
    do_reset(0);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(499) == 0;
      step($urandom_range(15) == 0, 16'($urandom), $urandom_range(9) < 7);
    end
    rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
